// File: rtl/pkt_sequencer_if.sv
// Packet type shared by the sequencer and its downstream counter block.
// Latency: n/a (type and bundle definitions only).
// Backpressure: none; packets are fire-and-forget.
package internal_pkg;

  typedef struct packed {
    logic        valid;
    logic [7:0]  addr;
    logic [63:0] data;
  } t_if_internal;

  localparam logic [7:0] ADDR_LOAD = 8'd128;
  localparam logic [7:0] ADDR_DEC  = 8'd130;

endpackage

// Bundle of the control, operand, packet and status signals of pkt_sequencer.
// master: the controller that starts sequences; slave: the sequencer itself.
interface pkt_sequencer_if;

  logic                        start;
  logic [63:0]                 load_value;
  logic [31:0]                 dec_count;
  logic [7:0]                  gap;
  logic                        sync_in;
  internal_pkg::t_if_internal  pkt_out;
  logic                        busy;
  logic                        done;
  logic                        pass;
  logic                        fail;

  modport master (
    output start, load_value, dec_count, gap, sync_in,
    input  pkt_out, busy, done, pass, fail
  );

  modport slave (
    input  start, load_value, dec_count, gap, sync_in,
    output pkt_out, busy, done, pass, fail
  );

endinterface

// File: rtl/pkt_sequencer.sv
// Emits one LOAD packet then dec_count DEC packets, then judges the downstream sync flag.
// Latency: LOAD packet appears the cycle after start is accepted; every output is registered.
// Backpressure: none; start is ignored while busy, packets are never stalled.
module pkt_sequencer #(
  parameter int unsigned WAIT_CYC = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  pkt_sequencer_if.slave bus
);

  import internal_pkg::*;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_DEC  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int unsigned WW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYC - 1);

  logic [2:0]    state_q,     state_d;
  logic [63:0]   load_q,      load_d;
  logic [31:0]   dec_q,       dec_d;
  logic [7:0]    gap_q,       gap_d;
  logic [31:0]   remaining_q, remaining_d;
  logic [7:0]    gap_cnt_q,   gap_cnt_d;
  logic [WW-1:0] wait_cnt_q,  wait_cnt_d;
  logic          seen_q,      seen_d;
  t_if_internal  pkt_q,       pkt_d;
  logic          busy_q,      busy_d;
  logic          done_q,      done_d;
  logic          pass_q,      pass_d;
  logic          fail_q,      fail_d;

  logic          expected;
  logic          any_sync;
  logic [31:0]   rem_next;

  // Next-state and next-output computation; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d     = state_q;
    load_d      = load_q;
    dec_d       = dec_q;
    gap_d       = gap_q;
    remaining_d = remaining_q;
    gap_cnt_d   = gap_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    seen_d      = seen_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    pkt_d       = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    rem_next    = remaining_q;

    // The downstream counter ends at zero exactly when the load value equals the decrement count.
    expected = (load_q == {32'b0, dec_q});
    any_sync = seen_q | bus.sync_in;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load_d      = bus.load_value;
          dec_d       = bus.dec_count;
          gap_d       = bus.gap;
          remaining_d = bus.dec_count;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          state_d     = S_LOAD;
        end
      end

      S_LOAD, S_DEC: begin
        // A DEC packet consumes one from the remaining count; LOAD does not.
        if (state_q == S_DEC) begin
          rem_next = remaining_q - 32'd1;
        end
        remaining_d = rem_next;
        if (rem_next == 32'd0) begin
          // No trailing gap: the last packet goes straight to the sync window.
          state_d    = S_WAIT;
          wait_cnt_d = '0;
          seen_d     = 1'b0;
        end else if (gap_q != 8'd0) begin
          state_d   = S_GAP;
          gap_cnt_d = gap_q;
        end else begin
          state_d = S_DEC;
        end
      end

      S_GAP: begin
        if (gap_cnt_q <= 8'd1) begin
          gap_cnt_d = 8'd0;
          state_d   = S_DEC;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end

      S_WAIT: begin
        seen_d = any_sync;
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_DONE;
          pass_d  = (expected == any_sync);
          fail_d  = (expected != any_sync);
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    if (state_d == S_LOAD) begin
      pkt_d.valid = 1'b1;
      pkt_d.addr  = ADDR_LOAD;
      pkt_d.data  = load_d;
    end else if (state_d == S_DEC) begin
      pkt_d.valid = 1'b1;
      pkt_d.addr  = ADDR_DEC;
      pkt_d.data  = 64'd0;
    end
  end

  // State and registered outputs; reset clears everything immediately, aborting any sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      load_q      <= '0;
      dec_q       <= '0;
      gap_q       <= '0;
      remaining_q <= '0;
      gap_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      seen_q      <= 1'b0;
      pkt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      dec_q       <= dec_d;
      gap_q       <= gap_d;
      remaining_q <= remaining_d;
      gap_cnt_q   <= gap_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      seen_q      <= seen_d;
      pkt_q       <= pkt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

  assign bus.pkt_out = pkt_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.fail    = fail_q;

endmodule

// File: tb/tb_pkt_sequencer.sv
// Self-checking bench for pkt_sequencer: directed scenarios plus randomized sequences.
// Expected packet timeline and verdict come from closed-form arithmetic over the operands.
// A small downstream counter model supplies sync_in in the directed cases.
module tb_pkt_sequencer;

  import internal_pkg::*;

  localparam int unsigned WAIT_CYC = 4;
  localparam int SYNC_COUNTER = 0;
  localparam int SYNC_RANDOM  = 1;
  localparam int SYNC_ZERO    = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pkt_sequencer_if bus ();

  pkt_sequencer #(.WAIT_CYC(WAIT_CYC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] mcnt = '0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one sequence (or its first max_cyc cycles) and checks every cycle against the timeline:
  // cycle 0 LOAD, DEC every (gap+1) cycles, WAIT_CYC sync cycles, one DONE cycle, then idle.
  task automatic run_seq(input logic [63:0] lv, input logic [31:0] dc, input logic [7:0] gp,
                         input int mode, input bit noise, input longint max_cyc);
    longint p;
    longint total;
    t_if_internal e;
    logic exp_any;
    logic exp_pass;
    p        = 1 + longint'(dc) * (longint'(gp) + 1);
    total    = p + WAIT_CYC + 1;
    exp_any  = 1'b0;
    exp_pass = 1'b0;
    bus.start      = 1'b1;
    bus.load_value = lv;
    bus.dec_count  = dc;
    bus.gap        = gp;
    step();
    for (longint i = 0; i <= total && i < max_cyc; i++) begin
      e = '0;
      if (i == 0) begin
        e.valid = 1'b1; e.addr = 8'd128; e.data = lv;
      end else if (i < p && ((i - 1) % (longint'(gp) + 1)) == longint'(gp)) begin
        e.valid = 1'b1; e.addr = 8'd130; e.data = 64'd0;
      end
      if (i == p + WAIT_CYC) begin
        exp_pass = (lv == {32'b0, dc}) ? exp_any : !exp_any;
      end
      check("pkt_out", 80'(bus.pkt_out), 80'(e));
      check("busy", 80'(bus.busy), 80'(i <= p + WAIT_CYC));
      check("done", 80'(bus.done), 80'(i == p + WAIT_CYC));
      if (i == 0) begin
        check("pass_cleared", 80'(bus.pass), 80'(0));
        check("fail_cleared", 80'(bus.fail), 80'(0));
      end
      if (i >= p + WAIT_CYC) begin
        check("pass", 80'(bus.pass), 80'(exp_pass));
        check("fail", 80'(bus.fail), 80'(!exp_pass));
      end
      // Drive sync for this cycle from state seen before this cycle's packet.
      case (mode)
        SYNC_COUNTER: bus.sync_in = (mcnt == 64'd0);
        SYNC_RANDOM:  bus.sync_in = 1'($urandom_range(0, 1));
        default:      bus.sync_in = 1'b0;
      endcase
      if (i >= p && i < p + WAIT_CYC) exp_any = exp_any | bus.sync_in;
      if (bus.pkt_out.valid && bus.pkt_out.addr == 8'd128) mcnt = bus.pkt_out.data;
      else if (bus.pkt_out.valid && bus.pkt_out.addr == 8'd130) mcnt = mcnt - 64'd1;
      // Stray starts with different operands while busy must change nothing.
      if (noise && i < p + WAIT_CYC + 1) begin
        bus.start      = 1'($urandom_range(0, 1));
        bus.load_value = {$urandom, $urandom};
        bus.dec_count  = $urandom;
        bus.gap        = 8'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      step();
    end
    bus.start   = 1'b0;
    bus.sync_in = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pkt"},  80'(bus.pkt_out), 80'(0));
    check({tag, "_busy"}, 80'(bus.busy), 80'(0));
    check({tag, "_done"}, 80'(bus.done), 80'(0));
    check({tag, "_pass"}, 80'(bus.pass), 80'(0));
    check({tag, "_fail"}, 80'(bus.fail), 80'(0));
  endtask

  initial begin
    logic [31:0] rdc;
    logic [7:0]  rgp;
    logic [63:0] rlv;
    bus.start      = 1'b0;
    bus.load_value = '0;
    bus.dec_count  = '0;
    bus.gap        = '0;
    bus.sync_in    = 1'b0;
    reset_n        = 1'b0;
    step();
    step();
    check_reset_state("reset");
    reset_n = 1'b1;
    step();
    check_reset_state("idle_after_reset");

    // Back-to-back packets, sync from counter model.
    run_seq(64'd3, 32'd3, 8'd0, SYNC_COUNTER, 1'b0, 1000);
    // Gapped packets, counter never reaches zero, expected mismatch gives pass.
    run_seq(64'd5, 32'd3, 8'd2, SYNC_COUNTER, 1'b0, 1000);
    // Sync stuck low when a zero was expected gives fail.
    run_seq(64'd5, 32'd5, 8'd0, SYNC_ZERO, 1'b0, 1000);
    // Single LOAD packet, immediate sync window, stray starts while busy.
    run_seq(64'd0, 32'd0, 8'd3, SYNC_COUNTER, 1'b1, 1000);
    // Transient zero mid-sequence is ignored; counter wraps.
    run_seq(64'd1, 32'd2, 8'd0, SYNC_COUNTER, 1'b0, 1000);
    check("counter_wrap", 80'(mcnt), 80'(64'hFFFF_FFFF_FFFF_FFFF));

    // Reset during the third DEC: valid must drop without waiting for a clock.
    run_seq(64'd10, 32'd10, 8'd0, SYNC_COUNTER, 1'b0, 3);
    check("pre_reset_valid", 80'(bus.pkt_out.valid), 80'(1));
    reset_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    step();
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("no_pkt_after_reset", 80'(bus.pkt_out), 80'(0));
      check("idle_after_abort", 80'(bus.busy), 80'(0));
    end
    // Fresh sequence after the abort.
    run_seq(64'd2, 32'd2, 8'd1, SYNC_COUNTER, 1'b0, 1000);

    // Huge decrement count: no overflow in packet scheduling; then abort.
    run_seq(64'd7, 32'hFFFF_FFFF, 8'd1, SYNC_ZERO, 1'b1, 40);
    reset_n = 1'b0;
    #1;
    check_reset_state("big_abort");
    step();
    reset_n = 1'b1;
    step();

    // Randomized sequences with random sync and random stray starts.
    for (int n = 0; n < 24; n++) begin
      rdc = 32'($urandom_range(0, 5));
      rgp = 8'($urandom_range(0, 3));
      rlv = ($urandom_range(0, 1) == 1) ? {32'b0, rdc} : 64'($urandom_range(0, 7));
      run_seq(rlv, rdc, rgp, SYNC_RANDOM, 1'($urandom_range(0, 1)), 1000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_sequencer.md
PKT_SEQUENCER -- requirements
Module: pkt_sequencer

Interface
REQ-001 SHALL expose parameter WAIT_CYC, default 4, meaning the number of cycles sync_in is sampled after the last packet.
REQ-002 SHALL expose: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL expose: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL expose: start  input  1  begin a sequence, honoured only in IDLE.
REQ-005 SHALL expose: load_value  input  64  counter value to write, captured on accepted start.
REQ-006 SHALL expose: dec_count  input  32  number of decrement packets, captured on accepted start.
REQ-007 SHALL expose: gap  input  8  idle cycles between consecutive packets, captured on accepted start.
REQ-008 SHALL expose: sync_in  input  1  sync flag returned by the downstream counter block.
REQ-009 SHALL expose: pkt_out  output  t_if_internal (internal_pkg)  packet with valid, addr, data fields.
REQ-010 SHALL expose: busy  output  1  high in every state except IDLE.
REQ-011 SHALL expose: done  output  1  one-cycle pulse at sequence end.
REQ-012 SHALL expose: pass, fail  output  1 each  result of last sequence, mutually exclusive.

Function
REQ-013 SHALL implement states IDLE, LOAD, GAP, DEC, WAIT_SYNC, DONE; all outputs registered.
REQ-014 In IDLE, start=1 SHALL capture load_value, dec_count, gap, clear pass/fail, and enter LOAD next cycle.
REQ-015 start while not IDLE SHALL be ignored; captured operands SHALL NOT change mid-sequence.
REQ-016 LOAD SHALL drive pkt_out.valid=1, addr=128, data=load_value for exactly one cycle.
REQ-017 After LOAD or DEC, SHALL spend exactly gap cycles in GAP with pkt_out.valid=0; gap=0 SHALL skip GAP (back-to-back packets).
REQ-018 DEC SHALL drive pkt_out.valid=1, addr=130, data=0 for one cycle and decrement a 32-bit remaining count.
REQ-019 After LOAD with dec_count=0, or after the DEC making remaining 0, SHALL enter WAIT_SYNC (via GAP if gap>0 only between packets, never before WAIT_SYNC).
REQ-020 pkt_out.valid SHALL be 0 in IDLE, GAP, WAIT_SYNC, DONE; addr/data SHALL be 0 whenever valid=0.
REQ-021 expected SHALL equal (load_value == {32'b0, dec_count}); 64-bit compare, no wrap modelling.
REQ-022 WAIT_SYNC SHALL last exactly WAIT_CYC cycles, sampling sync_in each cycle.
REQ-023 If expected=1, pass SHALL result when sync_in=1 in at least one sampled cycle, else fail.
REQ-024 If expected=0, pass SHALL result when sync_in=0 in every sampled cycle, else fail.
REQ-025 sync_in outside WAIT_SYNC (e.g. transient zero crossing when load_value<dec_count) SHALL be ignored.
REQ-026 DONE SHALL last one cycle: done=1, pass/fail set; then IDLE; pass/fail held until next accepted start.
REQ-027 Total packets per sequence SHALL be 1+dec_count; dec_count up to 2^32-1 SHALL be supported without overflow.

Reset
REQ-028 reset_n=0 SHALL asynchronously force IDLE, pkt_out all zero, busy=0, done=0, pass=0, fail=0, counters zero.
REQ-029 Reset mid-sequence SHALL abort immediately with no further packets; first start after release SHALL begin a fresh sequence.

Verification
REQ-030 load_value=3, dec_count=3, gap=0, sync_in from a model counter (2-cycle latency) -> packets 128/3, 130, 130, 130 on consecutive cycles, done with pass=1.
REQ-031 load_value=5, dec_count=3, gap=2 -> 2 idle cycles between each of 4 packets, sync_in stays 0, pass=1.
REQ-032 load_value=5, dec_count=5, sync_in forced 0 -> fail=1, pass=0, done one cycle.
REQ-033 load_value=0, dec_count=0 -> single 128/0 packet, immediate WAIT_SYNC, pass=1 with model counter; second start during busy ignored.
REQ-034 load_value=1, dec_count=2 -> sync pulses mid-sequence but is ignored, counter wraps to all-ones, pass=1.
REQ-035 reset_n asserted after second DEC of dec_count=10 -> pkt_out.valid drops same instant, busy=0, no further packets.
